// File: rtl/inverse_factorial.sv
// Inverse factorial: finds the largest n with n! <= f by repeated serial division.
// Optional busy-cycle counter output "cycles" is enabled by defining INVFACT_CYCLE_COUNT_EN.
`timescale 1ns/1ps

module inverse_factorial (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] f,
    output logic [7:0]  n,
    output logic        exact,
    output logic        ready
`ifdef INVFACT_CYCLE_COUNT_EN
    ,
    output logic [15:0] cycles
`endif
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHECK  = 3'd1,
        DIV    = 3'd2,
        UPDATE = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t      state_q, state_d;

    logic [31:0] r_q;
    logic [7:0]  k_q;
    logic        acc_q;
    logic        zf_q;
    logic [7:0]  n_q;
    logic        exact_q;

    // Divider working registers: quo_q shifts the dividend out and the quotient in.
    logic [32:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [4:0]  div_cnt_q;

    logic [32:0] trial;
    logic [32:0] k_ext;
    logic        q_bit;
    logic        r_lt_k;
    logic        div_last;
    logic        idle_or_done;
    logic        busy;

    assign idle_or_done = (state_q == IDLE) || (state_q == DONE);
    assign busy         = (state_q == CHECK) || (state_q == DIV) || (state_q == UPDATE);
    assign r_lt_k       = (r_q < {24'd0, k_q});
    assign div_last     = (div_cnt_q == 5'd31);

    // One restoring-division step per cycle.
    always_comb begin
        k_ext = {25'd0, k_q};
        trial = {rem_q[31:0], quo_q[31]};
        q_bit = 1'b0;
        rem_d = trial;
        if (trial >= k_ext) begin
            q_bit = 1'b1;
            rem_d = trial - k_ext;
        end
        quo_d = {quo_q[30:0], q_bit};
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CHECK;
            CHECK:   state_d = r_lt_k ? DONE : DIV;
            DIV:     if (div_last) state_d = UPDATE;
            UPDATE:  state_d = CHECK;
            DONE:    if (start) state_d = CHECK;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        ready = idle_or_done;
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q       <= 32'd0;
            k_q       <= 8'd2;
            acc_q     <= 1'b1;
            zf_q      <= 1'b0;
            n_q       <= 8'd0;
            exact_q   <= 1'b0;
            rem_q     <= 33'd0;
            quo_q     <= 32'd0;
            div_cnt_q <= 5'd0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        r_q   <= f;
                        k_q   <= 8'd2;
                        acc_q <= 1'b1;
                        zf_q  <= (f == 32'd0);
                    end
                end
                CHECK: begin
                    if (r_lt_k) begin
                        n_q     <= zf_q ? 8'd0 : (k_q - 8'd1);
                        exact_q <= ~zf_q & acc_q & (r_q == 32'd1);
                    end else begin
                        quo_q     <= r_q;
                        rem_q     <= 33'd0;
                        div_cnt_q <= 5'd0;
                    end
                end
                DIV: begin
                    rem_q     <= rem_d;
                    quo_q     <= quo_d;
                    div_cnt_q <= div_cnt_q + 5'd1;
                end
                UPDATE: begin
                    // R becomes floor(f / k!); any nonzero remainder rules out an exact match.
                    r_q   <= quo_q;
                    acc_q <= acc_q & (rem_q == 33'd0);
                    k_q   <= k_q + 8'd1;
                end
                default: ;
            endcase
        end
    end

    assign n     = n_q;
    assign exact = exact_q;

`ifdef INVFACT_CYCLE_COUNT_EN
    logic [15:0] cyc_q;
    logic        accept;

    assign accept = start && idle_or_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q <= 16'd0;
        end else if (accept) begin
            cyc_q <= 16'd0;
        end else if (busy && (cyc_q != 16'hFFFF)) begin
            cyc_q <= cyc_q + 16'd1;
        end
    end

    assign cycles = cyc_q;
`else
    logic unused_busy;
    assign unused_busy = busy;
`endif

endmodule

// File: tb/tb_inverse_factorial.sv
// Directed, table-driven bench for inverse_factorial, plus hand-written sequences
// for ignored start, mid-operation reset and reset/start priority.
`timescale 1ns/1ps

module tb_inverse_factorial;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] f;
    logic [7:0]  n;
    logic        exact;
    logic        ready;
`ifdef INVFACT_CYCLE_COUNT_EN
    logic [15:0] cycles;
`endif

    inverse_factorial dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .f     (f),
        .n     (n),
        .exact (exact),
        .ready (ready)
`ifdef INVFACT_CYCLE_COUNT_EN
        ,
        .cycles(cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] f;
        int          exp_n;
        int          exp_exact;
        int          exp_busy;
    } vec_t;

    vec_t vecs[12];
    int   n_checks;
    int   n_fails;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Starts an operation and counts negedges with ready low until it completes.
    task automatic run_op(input logic [31:0] fv, output int busy, output bit stable);
        logic [7:0] n0;
        logic       e0;
        @(negedge clk);
        start = 1'b1;
        f     = fv;
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        busy   = 0;
        stable = 1'b1;
        n0     = n;
        e0     = exact;
        while (!ready && busy < 2000) begin
            busy++;
            if (n !== n0 || exact !== e0) stable = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        int         busy;
        bit         stable;
        logic [7:0] n_hold;

        n_checks = 0;
        n_fails  = 0;
        rst      = 1'b1;
        start    = 1'b0;
        f        = 32'd0;

        vecs[0]  = '{32'd6,          3,  1, 69};
        vecs[1]  = '{32'd7,          3,  0, 69};
        vecs[2]  = '{32'd1,          1,  1, 1};
        vecs[3]  = '{32'd0,          0,  0, 1};
        vecs[4]  = '{32'd479001600,  12, 1, 375};
        vecs[5]  = '{32'hFFFFFFFF,   12, 0, 375};
        vecs[6]  = '{32'd2,          2,  1, 35};
        vecs[7]  = '{32'd5,          2,  0, 35};
        vecs[8]  = '{32'd24,         4,  1, 103};
        vecs[9]  = '{32'd25,         4,  0, 103};
        vecs[10] = '{32'd3628799,    9,  0, 273};
        vecs[11] = '{32'd39916800,   11, 1, 341};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_ready", ready, 1);
        check("reset_n", n, 0);
        check("reset_exact", exact, 0);
`ifdef INVFACT_CYCLE_COUNT_EN
        check("reset_cycles", cycles, 0);
`endif

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].f, busy, stable);
            $display("op f=%0d : n=%0d exact=%0d busy=%0d (exp n=%0d exact=%0d busy=%0d)",
                     vecs[i].f, n, exact, busy, vecs[i].exp_n, vecs[i].exp_exact, vecs[i].exp_busy);
            check($sformatf("vec%0d_n", i), n, vecs[i].exp_n);
            check($sformatf("vec%0d_exact", i), exact, vecs[i].exp_exact);
            check($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
            check($sformatf("vec%0d_stable", i), stable, 1);
`ifdef INVFACT_CYCLE_COUNT_EN
            check($sformatf("vec%0d_cycles", i), cycles, vecs[i].exp_busy);
`endif
        end

        // Results hold in DONE while idle.
        n_hold = n;
        repeat (5) @(negedge clk);
        check("hold_n", n, 11);
        check("hold_exact", exact, 1);
        check("hold_ready", ready, 1);
        $display("hold: n=%0d (was %0d) exact=%0d", n, n_hold, exact);

        // start pulse while busy is ignored.
        @(negedge clk);
        start = 1'b1;
        f     = 32'd120;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        busy  = 0;
        while (!ready && busy < 2000) begin
            busy++;
            if (busy == 10) begin
                start = 1'b1;
                f     = 32'd24;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        $display("op f=120 with start pulse at busy 10 : n=%0d exact=%0d busy=%0d", n, exact, busy);
        check("pulse_n", n, 5);
        check("pulse_exact", exact, 1);
        check("pulse_busy", busy, 137);

        // Mid-operation reset aborts and clears results.
        @(negedge clk);
        start = 1'b1;
        f     = 32'd5040;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        busy  = 1;
        while (busy < 40 && !ready) begin
            @(negedge clk);
            busy++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        $display("abort f=5040 at busy %0d : ready=%0d n=%0d exact=%0d", busy, ready, n, exact);
        check("abort_busy_reached", busy, 40);
        check("abort_ready", ready, 1);
        check("abort_n", n, 0);
        check("abort_exact", exact, 0);
`ifdef INVFACT_CYCLE_COUNT_EN
        check("abort_cycles", cycles, 0);
`endif
        run_op(32'd2, busy, stable);
        $display("op f=2 after abort : n=%0d exact=%0d busy=%0d", n, exact, busy);
        check("after_abort_n", n, 2);
        check("after_abort_exact", exact, 1);
        check("after_abort_busy", busy, 35);

        // Reset wins over start in the same cycle.
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        f     = 32'd6;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check("prio_ready0", ready, 1);
        @(negedge clk);
        $display("reset+start same cycle : ready=%0d n=%0d exact=%0d", ready, n, exact);
        check("prio_ready1", ready, 1);
        check("prio_n", n, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
